// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong state encoding and screen geometry
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOME  = 2'd1,
        REACT = 2'd2,
        TRACK = 2'd3
    } state_e;

    localparam logic [9:0] SCREEN_H = 10'd600;
    localparam logic [9:0] TOP      = 10'd5;
    localparam logic [9:0] BOTTOM   = 10'd590;
    localparam logic [9:0] HOME_Y   = 10'd300;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ai_player.sv
// rtl/ai_player.sv - computer paddle opponent driving up/down button pulses
module ai_player
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int REACT_TICKS = 8,
    parameter int DEADBAND    = 4,
    parameter int CENTER_OFS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] ball_y,
    input  logic       ball_toward,
    input  logic [9:0] pos_ply,
    output logic       btn_up,
    output logic       btn_down,
    output logic       tracking
);

    localparam int RW = (REACT_TICKS > 0) ? $clog2(REACT_TICKS + 1) : 1;
    localparam logic signed [11:0] DB = 12'(DEADBAND);
    localparam logic signed [11:0] CO = 12'(CENTER_OFS);

    logic tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e            state_q, state_d;
    logic [RW-1:0]     react_q, react_d;
    logic              btn_up_q, btn_up_d;
    logic              btn_down_q, btn_down_d;
    logic              tracking_q, tracking_d;
    logic [9:0]        target;
    logic              has_target;
    logic signed [11:0] err;
    logic              move;

    always_comb begin
        state_d = state_q;
        react_d = react_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = HOME;
                HOME: begin
                    if (ball_toward) begin
                        state_d = REACT;
                        react_d = '0;
                    end
                end
                REACT: begin
                    // Ball turning away wins over an expiring reaction delay.
                    if (!ball_toward) begin
                        state_d = HOME;
                    end else if (react_q == RW'(REACT_TICKS)) begin
                        state_d = TRACK;
                    end else if (tick) begin
                        react_d = react_q + 1'b1;
                    end
                end
                TRACK: begin
                    if (!ball_toward) state_d = HOME;
                end
                default: state_d = IDLE;
            endcase
        end

        target     = HOME_Y;
        has_target = 1'b0;
        case (state_q)
            HOME:    begin target = HOME_Y; has_target = 1'b1; end
            TRACK:   begin target = ball_y; has_target = 1'b1; end
            default: begin target = HOME_Y; has_target = 1'b0; end
        endcase

        err  = $signed({2'b00, target}) - $signed({2'b00, pos_ply}) - CO;
        move = tick && enable && has_target;

        btn_down_d = move && (err > DB) && (pos_ply < BOTTOM);
        btn_up_d   = move && (err < -DB) && (pos_ply > TOP);
        tracking_d = (state_d == TRACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            react_q    <= '0;
            btn_up_q   <= 1'b0;
            btn_down_q <= 1'b0;
            tracking_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            react_q    <= react_d;
            btn_up_q   <= btn_up_d;
            btn_down_q <= btn_down_d;
            tracking_q <= tracking_d;
        end
    end

    assign btn_up   = btn_up_q;
    assign btn_down = btn_down_q;
    assign tracking = tracking_q;

endmodule

// File: tb/tb_ai_player.sv
// tb/tb_ai_player.sv - scoreboard bench for ai_player with directed vectors
module tb_ai_player;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [9:0] ball_y = 10'd300;
    logic       ball_toward = 1'b0;
    logic [9:0] pos_ply = 10'd100;
    logic       btn_up;
    logic       btn_down;
    logic       tracking;

    ai_player #(
        .TICK_DIV    (4),
        .REACT_TICKS (2),
        .DEADBAND    (4),
        .CENTER_OFS  (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ball_y      (ball_y),
        .ball_toward (ball_toward),
        .pos_ply     (pos_ply),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .tracking    (tracking)
    );

    always #5 clk = ~clk;

    // Cycle k is the interval after the k-th rising edge following the last reset edge.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct { int cyc; bit up; } pulse_t;
    typedef struct { int cyc; bit val; } trk_t;

    pulse_t pulse_q[$];
    trk_t   trk_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic exp_pulse(input int c, input bit up);
        pulse_t p;
        p.cyc = c;
        p.up  = up;
        pulse_q.push_back(p);
    endtask

    task automatic exp_trk(input int c, input bit v);
        trk_t t;
        t.cyc = c;
        t.val = v;
        trk_q.push_back(t);
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor_loop();
        pulse_t p;
        trk_t   t;
        bit     prev_trk;
        prev_trk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (btn_up || btn_down) begin
                    if (btn_up && btn_down) begin
                        chk("buttons_exclusive", 1, 0);
                    end else if (pulse_q.size() == 0) begin
                        chk($sformatf("unexpected_pulse_cyc%0d_up", cyc), int'(btn_up), -1);
                    end else begin
                        p = pulse_q.pop_front();
                        chk("pulse_cycle", cyc, p.cyc);
                        chk($sformatf("pulse_dir_up_cyc%0d", cyc), int'(btn_up), int'(p.up));
                    end
                end
                if (tracking !== prev_trk) begin
                    if (trk_q.size() == 0) begin
                        chk($sformatf("unexpected_tracking_cyc%0d", cyc), int'(tracking), int'(prev_trk));
                    end else begin
                        t = trk_q.pop_front();
                        chk("tracking_edge_cycle", cyc, t.cyc);
                        chk("tracking_edge_value", int'(tracking), int'(t.val));
                    end
                    prev_trk = tracking;
                end
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
            begin
                #100000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_btn_up", int'(btn_up), 0);
        chk("rst_btn_down", int'(btn_down), 0);
        chk("rst_tracking", int'(tracking), 0);
        chk("rst_state", int'(dut.state_q), int'(IDLE));
        chk("rst_react", int'(dut.react_q), 0);

        // Return home from row 100: first tick in cycle 3, pulses every 4 cycles.
        exp_pulse(4, 0);
        exp_pulse(8, 0);
        exp_pulse(12, 0);
        // Deadband edge, then reaction and tracking.
        exp_pulse(28, 0);
        exp_trk(37, 1);
        exp_pulse(40, 1);
        exp_pulse(44, 1);
        exp_trk(46, 0);
        exp_pulse(48, 1);
        // Limits and abort.
        exp_trk(57, 1);
        exp_pulse(76, 0);
        exp_pulse(80, 1);
        exp_pulse(84, 1);
        exp_trk(85, 0);

        rst = 1'b0;

        goto(13); pos_ply = 10'd291;
        goto(17); pos_ply = 10'd296;
        goto(24); pos_ply = 10'd290;
        goto(29); pos_ply = 10'd300; ball_y = 10'd50; ball_toward = 1'b1;
        goto(30); chk("react_entered", int'(dut.state_q), int'(REACT));
        goto(45); ball_toward = 1'b0;
        goto(49); ball_y = 10'd0; pos_ply = 10'd5; ball_toward = 1'b1;
        goto(64); ball_y = 10'd599; pos_ply = 10'd590;
        goto(68); ball_y = 10'd700;
        goto(72); pos_ply = 10'd589;
        goto(77); ball_y = 10'd0; pos_ply = 10'd6;
        goto(84); enable = 1'b0;
        goto(86); chk("abort_state", int'(dut.state_q), int'(IDLE));
        goto(92); enable = 1'b1;
        goto(94); chk("pre_rst_state", int'(dut.state_q), int'(REACT));
        goto(95); rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_btn_up", int'(btn_up), 0);
        chk("mid_rst_btn_down", int'(btn_down), 0);
        chk("mid_rst_tracking", int'(tracking), 0);
        chk("mid_rst_state", int'(dut.state_q), int'(IDLE));
        chk("mid_rst_react", int'(dut.react_q), 0);
        rst = 1'b0;
        enable = 1'b0;
        goto(10);

        chk("pulse_queue_drained", pulse_q.size(), 0);
        chk("tracking_queue_drained", trk_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ai_player.md
# ai_player

Computer-controlled opponent for the Pong demo. The block drives the up/down button inputs of the paddle controller in place of a human, and reads back the paddle position that controller reports. It tracks the ball's vertical position with a programmable reaction delay, a deadband and a move-rate limit. When the ball travels away, the paddle returns to a home row.

## Interface
Parameters:
- TICK_DIV, 50000: clk cycles per move tick (≥1); at most one button pulse per tick.
- REACT_TICKS, 8: ticks to wait after the ball turns toward this paddle before tracking.
- DEADBAND, 4: no move while |error| ≤ DEADBAND pixels.
- CENTER_OFS, 5: offset from paddle top (pos_ply) to paddle centre.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = AI drives the paddle; 0 = outputs held low.
- ball_y  in  10  ball vertical position, pixels.
- ball_toward  in  1  1 = ball moving toward this paddle.
- pos_ply  in  10  current paddle position (feedback from paddle controller).
- btn_up  out  1  one-cycle pulse: move paddle up.
- btn_down  out  1  one-cycle pulse: move paddle down.
- tracking  out  1  high while state = TRACK.

## Operation
- Tick generator:
  - Free-running counter 0..TICK_DIV-1, independent of enable.
  - tick = 1 for one cycle when count == TICK_DIV-1, then count wraps to 0.
  - TICK_DIV=1 gives a tick every cycle.
- States: IDLE, HOME, REACT, TRACK. Reset → IDLE.
  - Any state, enable=0 → IDLE. This has priority over every other transition.
  - IDLE, enable=1 → HOME.
  - HOME, ball_toward=1 → REACT. The react counter is cleared on entry.
  - REACT:
    - Each tick increments the react counter.
    - Counter == REACT_TICKS → TRACK. With REACT_TICKS=0, REACT lasts exactly one cycle.
    - ball_toward=0 → HOME. This has priority over the counter check.
  - TRACK, ball_toward=0 → HOME.
- Target row: HOME_Y in HOME, ball_y in TRACK. No target in IDLE or REACT, so no pulses are issued there.
- Error computation:
  - err = target − (pos_ply + CENTER_OFS).
  - Computed as signed 12-bit, with zero-extended 10-bit operands. No overflow is possible.
- On a tick, in HOME or TRACK:
  - err > DEADBAND → btn_down pulse, unless pos_ply ≥ BOTTOM.
  - err < −DEADBAND → btn_up pulse, unless pos_ply ≤ TOP.
  - Otherwise no pulse.
- btn_up and btn_down are never high in the same cycle.

## Timing
- Reset values: btn_up=0, btn_down=0, tracking=0, state=IDLE, tick counter=0, react counter=0.
- State transitions take effect on the clock edge after their condition is sampled.
- Pulse latency:
  - Inputs are sampled in the tick cycle n.
  - The pulse is registered and high during cycle n+1 only.
  - The move decision uses the state register value in cycle n. A transition in the same cycle affects the next tick only.
- Pulse rate: with a steady error, pulses are exactly TICK_DIV cycles apart.
- tracking is registered and equals (state == TRACK).
- Mid-operation events:
  - enable falling during a pulse cycle: the registered pulse completes. No further pulses after that.
  - rst mid-operation: all registers return to reset values on the next edge, including any pulse in flight.
- ball_y and pos_ply are sampled every cycle. No input registering is required, because both are synchronous to clk.

## Structure
- Shared package pong_pkg:
  - State enum: IDLE, HOME, REACT, TRACK.
  - Screen constants: SCREEN_H=600, TOP=5, BOTTOM=590, HOME_Y=300.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick). It is reused by other timed Pong blocks.
- ai_player contains the FSM, react counter, error comparator and output registers.

## Test plan
All scenarios use TICK_DIV=4, REACT_TICKS=2, DEADBAND=4, CENTER_OFS=5.
- Reset: hold rst for 3 cycles with enable=1 → btn_up=btn_down=tracking=0, state IDLE; first tick occurs 4 cycles after rst falls.
- Return home: enable=1, ball_toward=0, pos_ply=100 (err=+195) → one-cycle btn_down every 4 cycles, btn_up never high.
- Deadband: HOME with pos_ply=291 (err=+4), then pos_ply=296 (err=−1) → no pulses. pos_ply=290 (err=+5) → btn_down on next tick.
- Reaction and tracking: pos_ply=300, ball_y=50, ball_toward rises → no pulses for 2 ticks, tracking rises, then btn_up each tick. Drop ball_toward → tracking low next cycle and HOME tracking resumes.
- Limits: TRACK, ball_y=0, pos_ply=5 → no btn_up. ball_y=599, pos_ply=590 → no btn_down.
- Abort: enable drops during TRACK → no pulse after the in-flight one, state IDLE. rst asserted in REACT → all outputs 0 next cycle, state IDLE.
